// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the N-tap FIR sequencing controller.
// Holds the ALU opcodes, the controller state encoding and the
// register-file address map (taps k are numbered 1..N).
package fir_ctrl_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_COPY  = 3'b001;
  localparam logic [2:0] OP_LOAD1 = 3'b010;
  localparam logic [2:0] OP_LOAD2 = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_STORE,
    ST_ZERO,
    ST_SORT,
    ST_MUL,
    ST_ACC,
    ST_EIDLE,
    ST_LDCOEF,
    ST_WTCOEF
  } state_t;

  // R0 holds the running sum.
  function automatic int unsigned acc_addr();
    return 0;
  endfunction

  // Sample history slot k (1 = oldest).
  function automatic int unsigned samp_addr(input int unsigned k);
    return k;
  endfunction

  // Slot the freshly arrived sample lands in.
  function automatic int unsigned new_addr(input int unsigned n);
    return n + 1;
  endfunction

  // Coefficient ck (k = 1..N).
  function automatic int unsigned coef_addr(input int unsigned n, input int unsigned k);
    return n + 1 + k;
  endfunction

  // Scratch register for the current product.
  function automatic int unsigned tmp_addr(input int unsigned n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/fir_controller_n.sv
// Micro-op sequencer for an N-tap FIR built on a register file and ALU.
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   dr                  new sample present
//   lc                  load-coefficient strobe
//   overflow            ALU overflow from the previous cycle's op
//   cnt_up, clear, done one-cycle status pulses
//   modwait, err        busy and error levels
//   src1, src2, op, dest  micro-op issued this cycle
// Every output is registered: the next-cycle values are decoded from the
// next state and next tap index, so outputs line up with the state itself.
module fir_controller_n
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned          NUM_TAPS  = 4,
  parameter int unsigned          ADDR_W    = 5,
  parameter logic [NUM_TAPS-1:0]  SIGN_MASK = NUM_TAPS'(4'b0101)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              dr,
  input  logic              lc,
  input  logic              overflow,
  output logic              cnt_up,
  output logic              clear,
  output logic              modwait,
  output logic              err,
  output logic              done,
  output logic [ADDR_W-1:0] src1,
  output logic [ADDR_W-1:0] src2,
  output logic [2:0]        op,
  output logic [ADDR_W-1:0] dest
);

  localparam int unsigned    IDX_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

  // Elaboration-time guards on the parameter set.
  if (NUM_TAPS < 2 || NUM_TAPS > 16) begin : g_bad_taps
    $error("fir_controller_n: NUM_TAPS must be 2..16");
  end
  if (2 * NUM_TAPS + 3 > 2 ** ADDR_W) begin : g_bad_addr
    $error("fir_controller_n: ADDR_W too small for register map");
  end

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               cnt_up_nxt, clear_nxt, modwait_nxt, err_nxt, done_nxt;
  logic [ADDR_W-1:0]  src1_nxt, src2_nxt, dest_nxt;
  logic [2:0]         op_nxt;
  logic [31:0]        tap;

  // State, tap counter and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      modwait <= 1'b0;
      cnt_up  <= 1'b0;
      clear   <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
      op      <= OP_NOP;
      src1    <= '1;
      src2    <= '1;
      dest    <= '1;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      modwait <= modwait_nxt;
      cnt_up  <= cnt_up_nxt;
      clear   <= clear_nxt;
      err     <= err_nxt;
      done    <= done_nxt;
      op      <= op_nxt;
      src1    <= src1_nxt;
      src2    <= src2_nxt;
      dest    <= dest_nxt;
    end
  end

  // Next state, next tap index and the micro-op for the next state.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    done_nxt    = 1'b0;
    cnt_up_nxt  = 1'b0;
    clear_nxt   = 1'b0;
    err_nxt     = 1'b0;
    modwait_nxt = 1'b0;
    op_nxt      = OP_NOP;
    src1_nxt    = '1;
    src2_nxt    = '1;
    dest_nxt    = '1;

    case (state)
      ST_IDLE, ST_EIDLE: begin
        if (dr) begin
          state_nxt = ST_STORE;
        end else if (lc) begin
          state_nxt = ST_LDCOEF;
          idx_nxt   = '0;
        end
      end
      ST_STORE: begin
        if (dr) begin
          state_nxt = ST_ZERO;
          idx_nxt   = '0;
        end else begin
          state_nxt = ST_EIDLE;
        end
      end
      ST_ZERO: begin
        state_nxt = ST_SORT;
        idx_nxt   = '0;
      end
      ST_SORT: begin
        if (idx == LAST_IDX) begin
          state_nxt = ST_MUL;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      ST_MUL: state_nxt = overflow ? ST_EIDLE : ST_ACC;
      ST_ACC: begin
        if (overflow) begin
          state_nxt = ST_EIDLE;
        end else if (idx == LAST_IDX) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = ST_MUL;
          idx_nxt   = idx + IDX_W'(1);
        end
      end
      ST_LDCOEF: state_nxt = (idx == LAST_IDX) ? ST_IDLE : ST_WTCOEF;
      ST_WTCOEF: begin
        if (lc) begin
          state_nxt = ST_LDCOEF;
          idx_nxt   = idx + IDX_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Tap number (1-based) addressed in the next state.
    tap = 32'(idx_nxt) + 32'd1;

    case (state_nxt)
      ST_STORE: begin
        op_nxt      = OP_LOAD1;
        dest_nxt    = ADDR_W'(new_addr(NUM_TAPS));
        modwait_nxt = 1'b1;
      end
      ST_ZERO: begin
        op_nxt      = OP_SUB;
        src1_nxt    = ADDR_W'(acc_addr());
        src2_nxt    = ADDR_W'(acc_addr());
        dest_nxt    = ADDR_W'(acc_addr());
        cnt_up_nxt  = 1'b1;
        modwait_nxt = 1'b1;
      end
      ST_SORT: begin
        op_nxt      = OP_COPY;
        dest_nxt    = ADDR_W'(samp_addr(tap));
        src1_nxt    = ADDR_W'(samp_addr(tap + 32'd1));
        modwait_nxt = 1'b1;
      end
      ST_MUL: begin
        op_nxt      = OP_MUL;
        dest_nxt    = ADDR_W'(tmp_addr(NUM_TAPS));
        src1_nxt    = ADDR_W'(coef_addr(NUM_TAPS, tap));
        src2_nxt    = ADDR_W'(samp_addr(tap));
        modwait_nxt = 1'b1;
      end
      ST_ACC: begin
        op_nxt      = SIGN_MASK[idx_nxt] ? OP_SUB : OP_ADD;
        dest_nxt    = ADDR_W'(acc_addr());
        src1_nxt    = ADDR_W'(acc_addr());
        src2_nxt    = ADDR_W'(tmp_addr(NUM_TAPS));
        modwait_nxt = 1'b1;
      end
      ST_EIDLE: err_nxt = 1'b1;
      ST_LDCOEF: begin
        op_nxt      = OP_LOAD2;
        dest_nxt    = ADDR_W'(coef_addr(NUM_TAPS, tap));
        clear_nxt   = (idx_nxt == '0);
        modwait_nxt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
